// File: rtl/core_biu_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : core_biu_arbiter
//  Purpose  : Shares the single BIU memory port between the instruction-fetch
//             requester (IFU) and the load/store requester (LSU). One
//             transaction is outstanding at a time. LSU wins ties, but an
//             anti-starvation counter forces an IFU grant after STARVE_MAX
//             consecutive LSU grants while fetch is waiting.
//  Revision : 1.0 - initial release
// ============================================================================
module core_biu_arbiter #(
    parameter int XLEN       = 32,
    parameter int STARVE_MAX = 4,
    parameter int CNT_W      = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    // instruction fetch requester
    input  logic            ifu_req_valid,
    output logic            ifu_req_ready,
    input  logic [XLEN-1:0] ifu_req_addr,
    output logic            ifu_rsp_valid,
    output logic [XLEN-1:0] ifu_rsp_data,
    input  logic            ifu_flush,
    // load/store requester
    input  logic            lsu_req_valid,
    output logic            lsu_req_ready,
    input  logic [XLEN-1:0] lsu_req_addr,
    input  logic            lsu_req_wen,
    input  logic [XLEN-1:0] lsu_req_wdata,
    output logic            lsu_rsp_valid,
    output logic [XLEN-1:0] lsu_rsp_data,
    // memory port towards the BIU
    output logic            mem_req_valid,
    input  logic            mem_req_ready,
    output logic [XLEN-1:0] mem_addr,
    output logic            mem_wen,
    output logic [XLEN-1:0] mem_wdata,
    input  logic            mem_rsp_valid,
    input  logic [XLEN-1:0] mem_rdata,
    // status
    output logic            arb_busy
);

    // FSM encoding
    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_REQ  = 2'd1;
    localparam logic [1:0] c_WAIT = 2'd2;

    // owner encoding
    localparam logic c_OWN_IFU = 1'b0;
    localparam logic c_OWN_LSU = 1'b1;

    localparam logic [CNT_W-1:0] c_STARVE_MAX = CNT_W'(STARVE_MAX);
    localparam logic [CNT_W-1:0] c_CNT_ONE    = CNT_W'(1);

    logic [1:0]       r_state;
    logic             r_owner;
    logic             r_kill;
    logic [CNT_W-1:0] r_starve_cnt;

    logic w_idle;
    logic w_ifu_forced;
    logic w_lsu_win;
    logic w_ifu_win;
    logic w_ifu_flush_hit;
    logic w_kill_now;

    // Grant decision: only taken in IDLE. LSU wins unless fetch has been
    // starved for STARVE_MAX consecutive LSU grants.
    assign w_idle       = (r_state == c_IDLE);
    assign w_ifu_forced = ifu_req_valid && (r_starve_cnt == c_STARVE_MAX);
    assign w_lsu_win    = w_idle && lsu_req_valid && !w_ifu_forced;
    assign w_ifu_win    = w_idle && ifu_req_valid && !w_lsu_win;

    // Handshake ready is the grant itself, so it is high for exactly the
    // IDLE cycle in which the request is captured.
    assign ifu_req_ready = w_ifu_win;
    assign lsu_req_ready = w_lsu_win;

    // A flush only matters while a fetch owns the bus; a flush arriving in
    // the same cycle as the response must also suppress that response.
    assign w_ifu_flush_hit = ifu_flush && (r_owner == c_OWN_IFU);
    assign w_kill_now      = r_kill || w_ifu_flush_hit;

    assign arb_busy = (r_state != c_IDLE);

    // Arbitration FSM with registered bus request, response routing,
    // flush-kill tracking and the starvation counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= c_IDLE;
            r_owner       <= c_OWN_IFU;
            r_kill        <= 1'b0;
            r_starve_cnt  <= '0;
            mem_req_valid <= 1'b0;
            mem_addr      <= '0;
            mem_wen       <= 1'b0;
            mem_wdata     <= '0;
            ifu_rsp_valid <= 1'b0;
            ifu_rsp_data  <= '0;
            lsu_rsp_valid <= 1'b0;
            lsu_rsp_data  <= '0;
        end else begin
            // response strobes are single-cycle pulses
            ifu_rsp_valid <= 1'b0;
            lsu_rsp_valid <= 1'b0;

            case (r_state)
                c_IDLE: begin
                    r_kill <= 1'b0;
                    if (w_lsu_win) begin
                        r_owner       <= c_OWN_LSU;
                        mem_addr      <= lsu_req_addr;
                        mem_wen       <= lsu_req_wen;
                        mem_wdata     <= lsu_req_wdata;
                        mem_req_valid <= 1'b1;
                        r_state       <= c_REQ;
                    end else if (w_ifu_win) begin
                        r_owner       <= c_OWN_IFU;
                        mem_addr      <= ifu_req_addr;
                        mem_wen       <= 1'b0;
                        mem_wdata     <= '0;
                        mem_req_valid <= 1'b1;
                        r_state       <= c_REQ;
                    end

                    // count LSU grants that overtook a waiting fetch
                    if (!ifu_req_valid || w_ifu_win) begin
                        r_starve_cnt <= '0;
                    end else if (w_lsu_win && (r_starve_cnt != c_STARVE_MAX)) begin
                        r_starve_cnt <= r_starve_cnt + c_CNT_ONE;
                    end
                end

                c_REQ: begin
                    if (w_ifu_flush_hit) begin
                        r_kill <= 1'b1;
                    end
                    // request stays presented until the BIU takes it
                    if (mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                        r_state       <= c_WAIT;
                    end
                end

                c_WAIT: begin
                    if (w_ifu_flush_hit) begin
                        r_kill <= 1'b1;
                    end
                    if (mem_rsp_valid) begin
                        r_state <= c_IDLE;
                        r_kill  <= 1'b0;
                        if (r_owner == c_OWN_LSU) begin
                            lsu_rsp_valid <= 1'b1;
                            lsu_rsp_data  <= mem_wen ? '0 : mem_rdata;
                        end else if (!w_kill_now) begin
                            ifu_rsp_valid <= 1'b1;
                            ifu_rsp_data  <= mem_rdata;
                        end
                    end
                end

                default: begin
                    r_state       <= c_IDLE;
                    r_kill        <= 1'b0;
                    mem_req_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_core_biu_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_core_biu_arbiter
//  Purpose  : Self-checking bench for core_biu_arbiter: vector table, a
//             behavioural BIU, and a response scoreboard, plus hand-written
//             starvation, flush and mid-transaction reset sequences.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_core_biu_arbiter;

    localparam int XLEN = 32;

    logic            clk;
    logic            rst_n;
    logic            ifu_req_valid;
    logic            ifu_req_ready;
    logic [XLEN-1:0] ifu_req_addr;
    logic            ifu_rsp_valid;
    logic [XLEN-1:0] ifu_rsp_data;
    logic            ifu_flush;
    logic            lsu_req_valid;
    logic            lsu_req_ready;
    logic [XLEN-1:0] lsu_req_addr;
    logic            lsu_req_wen;
    logic [XLEN-1:0] lsu_req_wdata;
    logic            lsu_rsp_valid;
    logic [XLEN-1:0] lsu_rsp_data;
    logic            mem_req_valid;
    logic            mem_req_ready;
    logic [XLEN-1:0] mem_addr;
    logic            mem_wen;
    logic [XLEN-1:0] mem_wdata;
    logic            mem_rsp_valid;
    logic [XLEN-1:0] mem_rdata;
    logic            arb_busy;

    core_biu_arbiter #(.XLEN(XLEN), .STARVE_MAX(4), .CNT_W(3)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ifu_req_valid (ifu_req_valid),
        .ifu_req_ready (ifu_req_ready),
        .ifu_req_addr  (ifu_req_addr),
        .ifu_rsp_valid (ifu_rsp_valid),
        .ifu_rsp_data  (ifu_rsp_data),
        .ifu_flush     (ifu_flush),
        .lsu_req_valid (lsu_req_valid),
        .lsu_req_ready (lsu_req_ready),
        .lsu_req_addr  (lsu_req_addr),
        .lsu_req_wen   (lsu_req_wen),
        .lsu_req_wdata (lsu_req_wdata),
        .lsu_rsp_valid (lsu_rsp_valid),
        .lsu_rsp_data  (lsu_rsp_data),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_addr      (mem_addr),
        .mem_wen       (mem_wen),
        .mem_wdata     (mem_wdata),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rdata     (mem_rdata),
        .arb_busy      (arb_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // scoreboard entry: one granted transaction
    typedef struct {
        bit          own;      // 1 = LSU
        logic [31:0] addr;
        bit          wen;
        logic [31:0] wdata;
        logic [31:0] data;     // expected response data
        int          gcyc;     // sample index of the grant
        int          lat;      // expected grant-to-pulse cycles
        bit          killed;
    } sb_t;

    typedef struct {
        bit          iv;
        logic [31:0] ia;
        bit          lv;
        logic [31:0] la;
        bit          wen;
        logic [31:0] wd;
        int          stall;
        int          lat;
        bit          exp_first;   // 1 = LSU granted first
        logic [31:0] exp_lsu;
    } vec_t;

    sb_t         sb_q[$];
    sb_t         pend;
    bit          pend_v;
    bit          in_wait;
    bit          grant_log[$];
    logic [31:0] last_lsu_data;
    int          n_tests;
    int          n_fail;
    int          cyc;
    int          biu_stall;
    int          biu_lat;
    bit          biu_manual;
    vec_t        vecs[6];

    // memory contents seen by the behavioural BIU
    function automatic logic [31:0] rdata_of(input logic [31:0] a);
        if (a == 32'h8000_0000) return 32'h0010_0093;
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic check32(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic fail_evt(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: got no event expected event", name);
    endtask

    // Behavioural BIU: stalls mem_req_ready for biu_stall cycles, then
    // answers biu_lat cycles after the minimum one-cycle latency.
    initial begin : biu
        int          stall_left;
        int          rsp_cd;
        logic [31:0] rsp_data;
        stall_left = -1;
        rsp_cd     = 0;
        rsp_data   = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stall_left = -1;
                rsp_cd     = 0;
            end
            if (biu_manual) continue;
            mem_rsp_valid = 1'b0;
            mem_req_ready = 1'b0;
            if (!rst_n) continue;
            if (rsp_cd > 0) begin
                rsp_cd--;
                if (rsp_cd == 0) begin
                    mem_rsp_valid = 1'b1;
                    mem_rdata     = rsp_data;
                end
            end
            if (mem_req_valid) begin
                if (stall_left < 0) stall_left = biu_stall;
                if (stall_left == 0) begin
                    mem_req_ready = 1'b1;
                    rsp_data      = mem_wen ? 32'hBAD0_BAD0 : rdata_of(mem_addr);
                    rsp_cd        = biu_lat + 1;
                    stall_left    = -1;
                end else begin
                    stall_left--;
                end
            end
        end
    end

    // Monitor / scoreboard, sampled mid-cycle after inputs settle.
    initial begin : mon
        sb_t         e;
        bit          prev_hold;
        logic [31:0] prev_addr;
        logic [31:0] prev_wdata;
        bit          prev_wen;
        prev_hold = 0;
        forever begin
            @(negedge clk);
            #3;
            cyc++;
            if (!rst_n) begin
                check32("reset_flags", {25'd0, ifu_req_ready, ifu_rsp_valid, lsu_req_ready,
                        lsu_rsp_valid, mem_req_valid, mem_wen, arb_busy}, 32'd0);
                check32("reset_ifu_rsp_data", ifu_rsp_data, 32'd0);
                check32("reset_lsu_rsp_data", lsu_rsp_data, 32'd0);
                check32("reset_mem_addr", mem_addr, 32'd0);
                check32("reset_mem_wdata", mem_wdata, 32'd0);
                sb_q.delete();
                pend_v    = 0;
                in_wait   = 0;
                prev_hold = 0;
            end else begin
                if (pend_v || ifu_rsp_valid || lsu_rsp_valid) begin
                    check32("ifu_rsp_valid", {31'd0, ifu_rsp_valid}, {31'd0, pend_v && !pend.own});
                    check32("lsu_rsp_valid", {31'd0, lsu_rsp_valid}, {31'd0, pend_v && pend.own});
                    if (pend_v) begin
                        check32("rsp_data", pend.own ? lsu_rsp_data : ifu_rsp_data, pend.data);
                        check32("rsp_latency", cyc - pend.gcyc, pend.lat);
                        if (pend.own) last_lsu_data = lsu_rsp_data;
                    end
                end
                pend_v = 0;

                if (ifu_flush && sb_q.size() > 0 && !sb_q[0].own) begin
                    e = sb_q[0];
                    e.killed = 1;
                    sb_q[0] = e;
                end

                if (prev_hold) begin
                    check32("hold_req_valid", {31'd0, mem_req_valid}, 32'd1);
                    check32("hold_addr", mem_addr, prev_addr);
                    check32("hold_wen", {31'd0, mem_wen}, {31'd0, prev_wen});
                    check32("hold_wdata", mem_wdata, prev_wdata);
                end

                if (in_wait && mem_rsp_valid) begin
                    in_wait = 0;
                    if (sb_q.size() == 0) begin
                        fail_evt("rsp_without_req");
                    end else begin
                        e = sb_q.pop_front();
                        if (!e.killed) begin
                            pend   = e;
                            pend_v = 1;
                        end
                    end
                end

                if (mem_req_valid && mem_req_ready) begin
                    if (sb_q.size() == 0) begin
                        fail_evt("accept_without_grant");
                    end else begin
                        check32("bus_addr", mem_addr, sb_q[0].addr);
                        check32("bus_wen", {31'd0, mem_wen}, {31'd0, sb_q[0].wen});
                        if (sb_q[0].wen) check32("bus_wdata", mem_wdata, sb_q[0].wdata);
                    end
                    in_wait = 1;
                end
                prev_hold  = mem_req_valid && !mem_req_ready;
                prev_addr  = mem_addr;
                prev_wen   = mem_wen;
                prev_wdata = mem_wdata;

                if (ifu_req_ready && lsu_req_ready) fail_evt("double_grant");
                if (ifu_req_valid && ifu_req_ready) begin
                    sb_q.push_back('{0, ifu_req_addr, 0, 32'd0, rdata_of(ifu_req_addr),
                                     cyc, 3 + biu_stall + biu_lat, 0});
                    grant_log.push_back(1'b0);
                end
                if (lsu_req_valid && lsu_req_ready) begin
                    sb_q.push_back('{1, lsu_req_addr, lsu_req_wen, lsu_req_wdata,
                                     lsu_req_wen ? 32'd0 : rdata_of(lsu_req_addr),
                                     cyc, 3 + biu_stall + biu_lat, 0});
                    grant_log.push_back(1'b1);
                end
            end
        end
    end

    // Present requests and hold each until its grant; returns cycles taken.
    task automatic issue(input bit iv, input logic [31:0] ia, input bit lv, input logic [31:0] la,
                         input bit wen, input logic [31:0] wd, output int ncyc);
        bit ig;
        bit lg;
        ig = !iv;
        lg = !lv;
        @(negedge clk);
        ifu_req_valid = iv;
        ifu_req_addr  = ia;
        lsu_req_valid = lv;
        lsu_req_addr  = la;
        lsu_req_wen   = wen;
        lsu_req_wdata = wd;
        ncyc = 0;
        while (!(ig && lg) && ncyc < 100) begin
            #2;
            if (ifu_req_valid && ifu_req_ready) ig = 1;
            if (lsu_req_valid && lsu_req_ready) lg = 1;
            @(negedge clk);
            if (ig) ifu_req_valid = 1'b0;
            if (lg) lsu_req_valid = 1'b0;
            ncyc++;
        end
        if (!(ig && lg)) begin
            fail_evt("grant_timeout");
            ifu_req_valid = 1'b0;
            lsu_req_valid = 1'b0;
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            #4;
            n++;
        end while ((sb_q.size() != 0 || pend_v || in_wait) && n < 300);
        if (n >= 300) fail_evt("idle_timeout");
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int  nc;
        int  n;
        bit  saw;
        n_tests = 0;
        n_fail  = 0;
        cyc     = 0;
        pend_v  = 0;
        in_wait = 0;
        biu_manual = 0;
        biu_stall  = 0;
        biu_lat    = 0;
        ifu_req_valid = 0; ifu_req_addr = '0; ifu_flush = 0;
        lsu_req_valid = 0; lsu_req_addr = '0; lsu_req_wen = 0; lsu_req_wdata = '0;
        mem_req_ready = 0; mem_rsp_valid = 0; mem_rdata = '0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        //           iv  ifu addr       lv  lsu addr       wen wdata          stl lat first exp lsu data
        vecs[0] = '{1, 32'h8000_0000, 0, 32'h0,         0, 32'h0,         0, 0, 0, 32'h0};
        vecs[1] = '{1, 32'h8000_0004, 1, 32'h0000_0100, 1, 32'hDEAD_BEEF, 0, 0, 1, 32'h0};
        vecs[2] = '{0, 32'h0,         1, 32'h0000_2000, 0, 32'h0,         2, 1, 1, rdata_of(32'h0000_2000)};
        vecs[3] = '{1, 32'h8000_0010, 0, 32'h0,         0, 32'h0,         5, 0, 0, 32'h0};
        vecs[4] = '{1, 32'h8000_0020, 1, 32'h0000_0044, 0, 32'h0,         1, 2, 1, rdata_of(32'h0000_0044)};
        vecs[5] = '{0, 32'h0,         1, 32'hFFFF_FFFC, 1, 32'h1234_5678, 0, 0, 1, 32'h0};

        for (int i = 0; i < 6; i++) begin
            biu_stall = vecs[i].stall;
            biu_lat   = vecs[i].lat;
            grant_log.delete();
            last_lsu_data = 'x;
            issue(vecs[i].iv, vecs[i].ia, vecs[i].lv, vecs[i].la, vecs[i].wen, vecs[i].wd, nc);
            wait_idle();
            check32($sformatf("vec%0d_grants", i), grant_log.size(), vecs[i].iv + vecs[i].lv);
            if (grant_log.size() > 0)
                check32($sformatf("vec%0d_first_owner", i), {31'd0, grant_log[0]}, {31'd0, vecs[i].exp_first});
            if (vecs[i].lv)
                check32($sformatf("vec%0d_lsu_data", i), last_lsu_data, vecs[i].exp_lsu);
        end

        // both requesters hammering: LSU x4 then a forced IFU grant
        biu_stall = 0;
        biu_lat   = 0;
        grant_log.delete();
        @(negedge clk);
        ifu_req_valid = 1; ifu_req_addr = 32'h8000_0100;
        lsu_req_valid = 1; lsu_req_addr = 32'h0000_0400; lsu_req_wen = 0;
        n = 0;
        while (grant_log.size() < 10 && n < 500) begin
            @(negedge clk);
            #4;
            n++;
        end
        @(negedge clk);
        ifu_req_valid = 0;
        lsu_req_valid = 0;
        wait_idle();
        if (grant_log.size() < 10) fail_evt("starve_pattern_len");
        for (int k = 0; k < 10 && k < grant_log.size(); k++)
            check32($sformatf("starve_grant%0d", k), {31'd0, grant_log[k]}, (k % 5 == 4) ? 32'd0 : 32'd1);

        // flush while a fetch waits for its response
        biu_lat = 3;
        issue(1, 32'h8000_0200, 0, 32'h0, 0, 32'h0, nc);
        @(negedge clk);
        ifu_flush = 1;
        @(negedge clk);
        ifu_flush = 0;
        saw = 0;
        for (int k = 0; k < 12; k++) begin
            #4;
            if (ifu_rsp_valid) saw = 1;
            @(negedge clk);
        end
        check32("flush_suppressed", {31'd0, saw}, 32'd0);
        check32("flush_busy_clear", {31'd0, arb_busy}, 32'd0);
        biu_lat = 0;
        issue(1, 32'h8000_0204, 0, 32'h0, 0, 32'h0, nc);
        check32("refetch_immediate", nc, 1);
        wait_idle();

        // reset in WAIT, then a stray late response
        biu_lat = 20;
        issue(1, 32'h8000_0300, 0, 32'h0, 0, 32'h0, nc);
        @(negedge clk);
        #4;
        check32("busy_in_wait", {31'd0, arb_busy}, 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        biu_manual = 1;
        mem_req_ready = 0;
        mem_rsp_valid = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        mem_rsp_valid = 1;
        mem_rdata = 32'hCAFE_F00D;
        @(negedge clk);
        mem_rsp_valid = 0;
        #4;
        check32("late_rsp_ifu_ignored", {31'd0, ifu_rsp_valid}, 32'd0);
        check32("late_rsp_lsu_ignored", {31'd0, lsu_rsp_valid}, 32'd0);
        check32("late_rsp_busy", {31'd0, arb_busy}, 32'd0);
        biu_manual = 0;
        biu_lat = 0;
        last_lsu_data = 'x;
        issue(1, 32'h8000_0000, 1, 32'h0000_0800, 0, 32'h0, nc);
        wait_idle();
        check32("post_reset_lsu_data", last_lsu_data, rdata_of(32'h0000_0800));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
